seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed N-digit seven-segment driver for the traffic-light display path. It accepts a binary countdown value through a valid/ready handshake, converts it to BCD with an iterative shift-add-3 engine, and latches the result into a display register. A scan counter then drives one digit at a time on a shared segment bus. It adds multi-digit scanning, leading-zero blanking, overflow indication and optional blinking.

---
 rtl/seg_pkg.sv | 53 +++++
 rtl/seg_bcd_iter.sv | 64 ++++++
 rtl/seg_scan_driver.sv | 185 ++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and helpers for the seven-segment scan driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed to hold 2^w - 1; sizes the internal BCD register.
  function automatic int bcd_digits(input int w);
    longint unsigned m;
    int n;
    m = (64'd1 << w) - 64'd1;
    n = 1;
    while (m >= 64'd10) begin
      m = m / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg_bcd_iter.sv
// Iterative double-dabble (shift-add-3) binary to BCD converter, one bit per clock.
// done_o flags the cycle whose edge performs the final iteration.
module seg_bcd_iter #(
  parameter int VALUE_W    = 7,
  parameter int BCD_DIGITS = 3,
  parameter int OUT_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*OUT_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(VALUE_W + 1);

  logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  assign done_o = busy_q && (cnt_q == CNT_W'(VALUE_W - 1));
  assign busy_o = busy_q;
  assign bcd_o  = bcd_q[4*OUT_DIGITS-1:0];

  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    adj    = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    if (start_i) begin
      bcd_d  = '0;
      bin_d  = value_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q + CNT_W'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver: handshake, BCD conversion, display register,
// scan, leading-zero blanking and overflow dashes. Define SEG_BLINK_EN to enable blinking.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int VALUE_W    = 7,
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  blank_lz,
  input  logic                  blink,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en
);

  localparam int NEED_DIGITS = bcd_digits(VALUE_W);
  localparam int INT_DIGITS  = (NUM_DIGITS > NEED_DIGITS) ? NUM_DIGITS : NEED_DIGITS;
  localparam int DISP_W      = 4 * NUM_DIGITS;
  localparam int PRESC_W     = $clog2(SCAN_DIV);
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam longint unsigned MAX_DISP = longint'(10 ** NUM_DIGITS) - 64'd1;

  state_e                state_q, state_d;
  logic                  ovf_q, ovf_d, blz_q, blz_d;
  logic [DISP_W-1:0]     disp_bcd_q, disp_bcd_d;
  logic                  disp_ovf_q, disp_ovf_d, disp_blz_q, disp_blz_d;
  logic                  disp_valid_q, disp_valid_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  accept, eng_busy, eng_done, presc_wrap, frame_wrap, blink_mask;
  logic [DISP_W-1:0]     eng_bcd;
  logic [3:0]            cur_digit;
  logic                  upper_zero;

  assign in_ready   = (state_q == ST_IDLE) && !eng_busy;
  assign accept     = in_valid && in_ready;
  assign presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
  assign frame_wrap = presc_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign seg        = seg_q;
  assign dig_en     = dig_en_q;

  seg_bcd_iter #(
    .VALUE_W   (VALUE_W),
    .BCD_DIGITS(INT_DIGITS),
    .OUT_DIGITS(NUM_DIGITS)
  ) u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start_i(accept),
    .value_i(value),
    .busy_o (eng_busy),
    .done_o (eng_done),
    .bcd_o  (eng_bcd)
  );

`ifdef SEG_BLINK_EN
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              boff_q, boff_d;

  // Phase toggles every BLINK_DIV full scan frames; dropping blink snaps back to the on phase.
  always_comb begin
    bcnt_d = bcnt_q;
    boff_d = boff_q;
    if (!blink) begin
      bcnt_d = '0;
      boff_d = 1'b0;
    end else if (frame_wrap) begin
      if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
        bcnt_d = '0;
        boff_d = ~boff_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= '0;
      boff_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      boff_q <= boff_d;
    end
  end

  assign blink_mask = blink && boff_d;
`else
  logic unused_blink;
  assign unused_blink = blink ^ (BLINK_DIV > 0);
  assign blink_mask   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ovf_d        = ovf_q;
    blz_d        = blz_q;
    disp_bcd_d   = disp_bcd_q;
    disp_ovf_d   = disp_ovf_q;
    disp_blz_d   = disp_blz_q;
    disp_valid_d = disp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ovf_d   = (64'(value) > MAX_DISP);
          blz_d   = blank_lz;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (eng_done) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_bcd_d   = eng_bcd;
        disp_ovf_d   = ovf_q;
        disp_blz_d   = blz_q;
        disp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state index and display so seg and dig_en move together.
  always_comb begin
    presc_d    = presc_wrap ? '0 : presc_q + PRESC_W'(1);
    idx_d      = idx_q;
    if (presc_wrap) idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    cur_digit  = '0;
    upper_zero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_digit  = disp_bcd_d[4*i +: 4];
        upper_zero = (i > 0);
        for (int j = i; j < NUM_DIGITS; j++) begin
          if (disp_bcd_d[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        end
      end
    end
    if (!disp_valid_d)                   seg_d = SEG_BLANK;
    else if (disp_ovf_d)                 seg_d = SEG_DASH;
    else if (disp_blz_d && upper_zero)   seg_d = SEG_BLANK;
    else                                 seg_d = digit_to_seg(cur_digit);
    if (blink_mask) seg_d = SEG_BLANK;
    dig_en_d = disp_valid_d ? (NUM_DIGITS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ovf_q        <= 1'b0;
      blz_q        <= 1'b0;
      disp_bcd_q   <= '0;
      disp_ovf_q   <= 1'b0;
      disp_blz_q   <= 1'b0;
      disp_valid_q <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      dig_en_q     <= '0;
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_d;
      blz_q        <= blz_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_ovf_q   <= disp_ovf_d;
      disp_blz_q   <= disp_blz_d;
      disp_valid_q <= disp_valid_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      dig_en_q     <= dig_en_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: stimulus pushes expected {dig_en, seg} slots,
// a monitor pops each one when the DUT scans to that digit. Honors SEG_BLINK_EN.
module tb_seg_scan_driver;

  localparam logic [6:0] S0 = 7'b1111110, S2 = 7'b1101101, S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011, S7 = 7'b1110000, S9 = 7'b1111011;
  localparam logic [6:0] SDASH = 7'b0000001, SOFF = 7'b0000000;

  typedef struct {
    logic [1:0] digEn;
    logic [6:0] segVal;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic       inReady;
  logic [6:0] value = '0;
  logic       blankLz = 1'b0;
  logic       blink = 1'b0;
  logic [6:0] seg;
  logic [1:0] digEn;

  int testCount = 0;
  int failCount = 0;
  exp_t expQ[$];

  seg_scan_driver #(
    .NUM_DIGITS(2),
    .VALUE_W   (7),
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(inValid),
    .in_ready(inReady),
    .value   (value),
    .blank_lz(blankLz),
    .blink   (blink),
    .seg     (seg),
    .dig_en  (digEn)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [1:0] d, input logic [6:0] s, input string name);
    exp_t e;
    e.digEn  = d;
    e.segVal = s;
    e.name   = name;
    expQ.push_back(e);
  endtask

  // Monitor: compare the head slot as soon as the DUT enables that digit.
  initial begin
    int waitCnt;
    exp_t e;
    waitCnt = 0;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        e = expQ[0];
        if (digEn == e.digEn) begin
          checkOutput(e.name, 32'(seg), 32'(e.segVal));
          void'(expQ.pop_front());
          waitCnt = 0;
        end else begin
          waitCnt++;
          if (waitCnt > 40) begin
            checkOutput({e.name, " scan timeout"}, 32'(digEn), 32'(e.digEn));
            void'(expQ.pop_front());
            waitCnt = 0;
          end
        end
      end
    end
  end

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("drain timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
  endtask

  task automatic waitReady(output int lowCnt);
    lowCnt = 0;
    while (!inReady && lowCnt < 50) begin
      @(posedge clk);
      #1;
      lowCnt++;
    end
  endtask

  task automatic applyStimulus(input logic [6:0] v, input logic blz);
    int lowCnt;
    @(negedge clk);
    checkOutput("ready before accept", 32'(inReady), 32'd1);
    value   = v;
    blankLz = blz;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    waitReady(lowCnt);
    checkOutput("ready low cycles", 32'(lowCnt), 32'd8);
  endtask

  task automatic waitDigit(input logic [1:0] d, input string name);
    int n;
    n = 0;
    while (digEn != d && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (digEn != d) checkOutput({name, " sync timeout"}, 32'(digEn), 32'(d));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int runLen;
    int lowCnt;
    logic [6:0] off2, off4;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset seg", 32'(seg), 32'(SOFF));
    checkOutput("reset dig_en", 32'(digEn), 32'd0);
    checkOutput("reset in_ready", 32'(inReady), 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("dark before commit dig_en", 32'(digEn), 32'd0);
    checkOutput("dark before commit seg", 32'(seg), 32'(SOFF));

    applyStimulus(7'd57, 1'b0);
    pushExp(2'b01, S7, "57 units");
    pushExp(2'b10, S5, "57 tens");
    waitDrain();
    waitDigit(2'b10, "hold");
    waitDigit(2'b01, "hold");
    runLen = 0;
    while (digEn == 2'b01 && runLen < 20) begin
      @(negedge clk);
      runLen++;
    end
    checkOutput("digit hold cycles", 32'(runLen), 32'd4);

    applyStimulus(7'd5, 1'b1);
    pushExp(2'b01, S5, "5 lz units");
    pushExp(2'b10, SOFF, "5 lz tens blank");
    waitDrain();

    applyStimulus(7'd5, 1'b0);
    pushExp(2'b10, S0, "5 nolz tens");
    pushExp(2'b01, S5, "5 nolz units");
    waitDrain();

    applyStimulus(7'd0, 1'b1);
    pushExp(2'b01, S0, "0 lz units");
    pushExp(2'b10, SOFF, "0 lz tens blank");
    waitDrain();

    applyStimulus(7'd120, 1'b0);
    pushExp(2'b01, SDASH, "ovf units");
    pushExp(2'b10, SDASH, "ovf tens");
    waitDrain();

    applyStimulus(7'd99, 1'b1);
    pushExp(2'b01, S9, "99 units");
    pushExp(2'b10, S9, "99 tens");
    waitDrain();

    @(negedge clk);
    value   = 7'd57;
    blankLz = 1'b0;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("busy during convert", 32'(inReady), 32'd0);
    value   = 7'd33;
    inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    waitReady(lowCnt);
    checkOutput("ready after ignored pulse", 32'(inReady), 32'd1);
    pushExp(2'b01, S7, "ignored 33 units");
    pushExp(2'b10, S5, "ignored 33 tens");
    waitDrain();

    @(negedge clk);
    value   = 7'd42;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid-reset seg", 32'(seg), 32'(SOFF));
    checkOutput("mid-reset dig_en", 32'(digEn), 32'd0);
    checkOutput("mid-reset in_ready", 32'(inReady), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("no partial commit dig_en", 32'(digEn), 32'd0);
    checkOutput("no partial commit seg", 32'(seg), 32'(SOFF));

    applyStimulus(7'd42, 1'b0);
    pushExp(2'b01, S2, "42 units");
    pushExp(2'b10, S4, "42 tens");
    waitDrain();

`ifdef SEG_BLINK_EN
    off2 = SOFF;
    off4 = SOFF;
`else
    off2 = S2;
    off4 = S4;
`endif
    waitDigit(2'b10, "blink");
    waitDigit(2'b01, "blink");
    blink = 1'b1;
    pushExp(2'b01, S2, "blink f0 units");
    pushExp(2'b10, S4, "blink f0 tens");
    pushExp(2'b01, S2, "blink f1 units");
    pushExp(2'b10, S4, "blink f1 tens");
    pushExp(2'b01, off2, "blink f2 units");
    pushExp(2'b10, off4, "blink f2 tens");
    pushExp(2'b01, off2, "blink f3 units");
    pushExp(2'b10, off4, "blink f3 tens");
    pushExp(2'b01, S2, "blink f4 units");
    pushExp(2'b10, S4, "blink f4 tens");
    waitDrain();
    blink = 1'b0;
    pushExp(2'b01, S2, "blink off units");
    pushExp(2'b10, S4, "blink off tens");
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
